// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl: gathers A, B and opcode bytes from the UART receiver,
// feeds them to the ALU, then sends the ALU result through the transmitter.
//
// Ports:
//   i_clk, i_reset     rising-edge clock, synchronous active-high reset
//   i_tick             baud tick, only used by the inter-byte timeout
//   i_rx_done/i_rx_data  received byte strobe and data
//   i_tx_done          transmitter finished strobe
//   i_alu_result       combinational ALU result of o_alu_a/o_alu_b/o_alu_op
//   o_alu_a/b/op       registered ALU operands and opcode
//   o_tx_data/o_tx_start  byte to send and one-cycle launch pulse
//   o_busy             high while a result is being sent
//   o_timeout          one-cycle pulse when a partial command is dropped
//
// Optional feature: define UART_CTRL_TIMEOUT_EN to build the inter-byte
// timeout. Without it o_timeout is tied low and i_tick is ignored.

module uart_alu_ctrl #(
  parameter int NB_DATA       = 8,
  parameter int NB_OP         = 6,
  parameter int NB_TIMEOUT    = 12,
  parameter int TIMEOUT_TICKS = 4000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_tx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_timeout
);

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    SEND,
    WAIT_TX
  } state_t;

  state_t state;
  logic   expire;

  assign o_busy = (state == SEND) || (state == WAIT_TX);

`ifdef UART_CTRL_TIMEOUT_EN
  logic [NB_TIMEOUT-1:0] cnt;
  logic                  in_window;

  assign in_window = (state == WAIT_B) || (state == WAIT_OP);

  // A byte arriving on the expiry tick takes priority over the abort.
  assign expire = in_window && i_tick && !i_rx_done &&
                  (cnt == NB_TIMEOUT'(TIMEOUT_TICKS - 1));

  // Every state change out of WAIT_B/WAIT_OP is caused by either a
  // received byte or an expiry, so clearing on those covers it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt <= '0;
    end else if (!in_window || i_rx_done || expire) begin
      cnt <= '0;
    end else if (i_tick) begin
      cnt <= cnt + NB_TIMEOUT'(1);
    end
  end
`else
  logic [NB_TIMEOUT:0] cfg_unused;

  assign expire     = 1'b0;
  assign cfg_unused = {i_tick, NB_TIMEOUT'(TIMEOUT_TICKS - 1)};
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= WAIT_A;
      o_alu_a    <= '0;
      o_alu_b    <= '0;
      o_alu_op   <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_timeout  <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_timeout  <= 1'b0;
      if (expire) begin
        state     <= WAIT_A;
        o_timeout <= 1'b1;
      end else begin
        case (state)
          WAIT_A: begin
            if (i_rx_done) begin
              o_alu_a <= i_rx_data;
              state   <= WAIT_B;
            end
          end
          WAIT_B: begin
            if (i_rx_done) begin
              o_alu_b <= i_rx_data;
              state   <= WAIT_OP;
            end
          end
          WAIT_OP: begin
            if (i_rx_done) begin
              o_alu_op <= i_rx_data[NB_OP-1:0];
              state    <= SEND;
            end
          end
          SEND: begin
            // Operands settled last cycle, so the ALU result is valid now.
            o_tx_data  <= i_alu_result;
            o_tx_start <= 1'b1;
            state      <= WAIT_TX;
          end
          WAIT_TX: begin
            if (i_tx_done) begin
              state <= WAIT_A;
            end
          end
          default: state <= WAIT_A;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// tb_uart_alu_ctrl: randomized command stream against a behavioural model
// of the command protocol and a reference ALU.

module tb_uart_alu_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       tx_done;
  logic [7:0] alu_result;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [5:0] alu_op;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       timeout;

  int vectors = 0;
  int errs    = 0;

  logic [7:0] ma;
  logic [7:0] mb;
  logic [5:0] mop;

  logic [5:0] ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25,
                          6'h26, 6'h27, 6'h02, 6'h03};

  always #5 clk = ~clk;

  uart_alu_ctrl #(
    .NB_DATA      (8),
    .NB_OP        (6),
    .NB_TIMEOUT   (12),
    .TIMEOUT_TICKS(8)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_tick      (tick),
    .i_rx_done   (rx_done),
    .i_rx_data   (rx_data),
    .i_tx_done   (tx_done),
    .i_alu_result(alu_result),
    .o_alu_a     (alu_a),
    .o_alu_b     (alu_b),
    .o_alu_op    (alu_op),
    .o_tx_data   (tx_data),
    .o_tx_start  (tx_start),
    .o_busy      (busy),
    .o_timeout   (timeout)
  );

  function automatic logic [7:0] alu(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [5:0] op
  );
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h02:   return a >> b[2:0];
      6'h03:   return 8'($signed(a) >>> b[2:0]);
      default: return 8'h00;
    endcase
  endfunction

  assign alu_result = alu(alu_a, alu_b, alu_op);

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
               $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic stray);
    tx_done = stray;
    for (int i = 0; i < n; i++) step();
    tx_done = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_done = 1'b1;
    rx_data = b;
    step();
    rx_done = 1'b0;
    rx_data = $urandom();
  endtask

  task automatic finish_cmd(
    input logic [7:0] op,
    input int         dly,
    input bit         junk
  );
    logic [7:0] exp;
    send_byte(op);
    mop = op[5:0];
    exp = alu(ma, mb, mop);
    check("alu_a", alu_a, ma);
    check("alu_b", alu_b, mb);
    check("alu_op", alu_op, mop);
    check("start_early", tx_start, 0);
    check("busy_send", busy, 1);
    step();
    check("tx_start", tx_start, 1);
    check("tx_data", tx_data, exp);
    if (junk) send_byte(8'h7F);
    else step();
    check("start_once", tx_start, 0);
    check("alu_a_hold", alu_a, ma);
    for (int i = 0; i < dly; i++) begin
      check("busy_wait", busy, 1);
      step();
    end
    check("busy_pre_done", busy, 1);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check("busy_after", busy, 0);
    check("tx_data_hold", tx_data, exp);
  endtask

  task automatic run_cmd(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] op,
    input int         gap,
    input int         dly,
    input bit         junk
  );
    send_byte(a);
    ma = a;
    idle(gap, $urandom_range(0, 1) == 1);
    check("busy_idle", busy, 0);
    send_byte(b);
    mb = b;
    idle(gap, 1'b0);
    finish_cmd(op, dly, junk);
  endtask

  initial begin
    reset   = 1'b1;
    tick    = 1'b0;
    rx_done = 1'b0;
    rx_data = '0;
    tx_done = 1'b0;
    ma      = '0;
    mb      = '0;
    mop     = '0;
    idle(3, 1'b0);
    reset = 1'b0;
    idle(20, 1'b0);
    check("rst_busy", busy, 0);
    check("rst_start", tx_start, 0);
    check("rst_a", alu_a, 0);
    check("rst_b", alu_b, 0);
    check("rst_op", alu_op, 0);
    check("rst_tx", tx_data, 0);
    check("rst_to", timeout, 0);

    run_cmd(8'h05, 8'h03, 8'h20, 0, 2, 1'b0);
    run_cmd(8'h09, 8'h04, 8'hE2, 1, 3, 1'b1);
    check("trunc_op", alu_op, 6'h22);
    run_cmd(8'h0A, 8'h0C, 8'h24, 0, 0, 1'b0);

    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h25);
    step();
    check("pre_rst_start", tx_start, 1);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    ma = '0;
    mb = '0;
    mop = '0;
    check("wtx_rst_busy", busy, 0);
    check("wtx_rst_a", alu_a, 0);
    check("wtx_rst_b", alu_b, 0);
    check("wtx_rst_op", alu_op, 0);
    check("wtx_rst_tx", tx_data, 0);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check("late_done_busy", busy, 0);
    check("late_done_start", tx_start, 0);
    run_cmd(8'h81, 8'h02, 8'h03, 0, 1, 1'b0);

`ifdef UART_CTRL_TIMEOUT_EN
    send_byte(8'h11);
    ma = 8'h11;
    for (int i = 0; i < 8; i++) begin
      check("to_early", timeout, 0);
      idle($urandom_range(0, 2), 1'b0);
      tick = 1'b1;
      step();
      tick = 1'b0;
    end
    check("to_pulse", timeout, 1);
    check("to_busy", busy, 0);
    check("to_a_hold", alu_a, 8'h11);
    step();
    check("to_single", timeout, 0);
    run_cmd(8'h21, 8'h07, 8'h22, 0, 0, 1'b0);

    send_byte(8'h11);
    ma = 8'h11;
    for (int i = 0; i < 7; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
    end
    tick = 1'b1;
    send_byte(8'h44);
    tick = 1'b0;
    mb = 8'h44;
    check("race_no_to", timeout, 0);
    check("race_b", alu_b, 8'h44);
    finish_cmd(8'h26, 1, 1'b0);
`else
    send_byte(8'h11);
    ma = 8'h11;
    for (int i = 0; i < 20; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      check("no_to", timeout, 0);
    end
    check("hold_a", alu_a, 8'h11);
    send_byte(8'h44);
    mb = 8'h44;
    finish_cmd(8'h26, 1, 1'b0);
`endif

    for (int n = 0; n < 40; n++) begin
      logic [7:0] op;
      op = {2'($urandom()), ops[$urandom_range(0, 7)]};
      run_cmd($urandom(), $urandom(), op, $urandom_range(0, 3),
              $urandom_range(0, 5), $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
